uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: frame receiver for an Rx_Enable-strobed serial line.
// Frame: start 0, DATA_WIDTH data bits LSB first, even parity (XOR of data), stop 1.
// A completed frame is always delivered with its error flags. An unacknowledged
// word that gets overwritten raises Overrun.
module uart_receiver #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Rx_Serial_Input,
    input  logic                  Rx_Enable,
    input  logic                  Rx_Ack,
    output logic [DATA_WIDTH-1:0] Rx_Data,
    output logic                  Rx_Valid,
    output logic                  Rx_Busy,
    output logic                  Parity_Error,
    output logic                  Frame_Error,
    output logic                  Overrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] sr_q,       sr_d;
    logic                  perr_pnd_q, perr_pnd_d;
    logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  perr_q,     perr_d;
    logic                  ferr_q,     ferr_d;
    logic                  ovr_q,      ovr_d;

    logic                  complete;

    // A frame completes on the enabled cycle that samples the stop bit
    assign complete = (state_q == STOP) && Rx_Enable;

    // Frame FSM, bit counter and shift register; disabled cycles hold everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        perr_pnd_d = perr_pnd_q;
        if (Rx_Enable) begin
            unique case (state_q)
                IDLE: begin
                    if (!Rx_Serial_Input) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    sr_d  = {Rx_Serial_Input, sr_q[DATA_WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_pnd_d = (Rx_Serial_Input != ^sr_q);
                    state_d    = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Delivery registers: a completion outranks an acknowledge in the same cycle
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        if (complete) begin
            rx_data_d  = sr_q;
            rx_valid_d = 1'b1;
            perr_d     = perr_pnd_q;
            ferr_d     = ~Rx_Serial_Input;
            if (rx_valid_q) begin
                ovr_d = ~Rx_Ack;
            end
        end else if (Rx_Ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            ovr_d      = 1'b0;
        end
    end

    // State register with synchronous reset; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            perr_pnd_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            perr_pnd_q <= perr_pnd_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign Rx_Data      = rx_data_q;
    assign Rx_Valid     = rx_valid_q;
    assign Rx_Busy      = (state_q != IDLE);
    assign Parity_Error = perr_q;
    assign Frame_Error  = ferr_q;
    assign Overrun      = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with DATA_WIDTH = 32.
module tb_uart_receiver;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        en;
    logic        ack;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        perr;
    logic        ferr;
    logic        ovr;

    int checks;
    int failures;
    int busy_cycles;

    uart_receiver #(.DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rx_Serial_Input (rx),
        .Rx_Enable       (en),
        .Rx_Ack          (ack),
        .Rx_Data         (rx_data),
        .Rx_Valid        (rx_valid),
        .Rx_Busy         (rx_busy),
        .Parity_Error    (perr),
        .Frame_Error     (ferr),
        .Overrun         (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_busy) busy_cycles++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        en = 1'b1;
        tick();
    endtask

    // Full frame; optional 5-cycle stall before data bit stall_at, optional ack on the stop cycle
    task automatic send_frame(input logic [31:0] d, input logic par, input logic stp,
                              input int stall_at, input logic ack_on_stop);
        busy_cycles = 0;
        send_bit(1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 5; s++) begin
                    en = 1'b0;
                    rx = s[0];
                    tick();
                end
            end
            send_bit(d[i]);
        end
        send_bit(par);
        ack = ack_on_stop;
        send_bit(stp);
        ack = 1'b0;
        rx  = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        busy_cycles = 0;
        rst = 1'b1;
        rx  = 1'b1;
        en  = 1'b0;
        ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_data",  64'(rx_data),  64'h0);
        check("rst_valid", 64'(rx_valid), 64'h0);
        check("rst_busy",  64'(rx_busy),  64'h0);
        check("rst_flags", 64'({perr, ferr, ovr}), 64'h0);

        // Idle line with enable and a stray ack: nothing happens
        ack = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        ack = 1'b0;
        check("idle_busy",  64'(rx_busy),  64'h0);
        check("idle_valid", 64'(rx_valid), 64'h0);

        // Clean frame
        send_frame(32'hA5A50F0F, 1'b0, 1'b1, -1, 1'b0);
        check("clean_valid", 64'(rx_valid), 64'h1);
        check("clean_data",  64'(rx_data),  64'hA5A50F0F);
        check("clean_flags", 64'({perr, ferr, ovr}), 64'h0);
        check("clean_busy_cycles", 64'(busy_cycles), 64'd34);
        check("clean_busy_after", 64'(rx_busy), 64'h0);
        do_ack();
        check("clean_ack_valid", 64'(rx_valid), 64'h0);
        check("clean_ack_data_hold", 64'(rx_data), 64'hA5A50F0F);

        // Parity error: 0x00000001 needs parity 1, send 0
        send_frame(32'h00000001, 1'b0, 1'b1, -1, 1'b0);
        check("par_data",  64'(rx_data),  64'h00000001);
        check("par_valid", 64'(rx_valid), 64'h1);
        check("par_perr",  64'(perr),     64'h1);
        check("par_ferr",  64'(ferr),     64'h0);
        do_ack();
        check("par_ack_valid", 64'(rx_valid), 64'h0);
        check("par_ack_perr",  64'(perr),     64'h0);

        // Stall mid-data plus a zero stop bit; 0x12345678 has odd weight so parity 1
        send_frame(32'h12345678, 1'b1, 1'b0, 16, 1'b0);
        check("frm_data",  64'(rx_data),  64'h12345678);
        check("frm_ferr",  64'(ferr),     64'h1);
        check("frm_perr",  64'(perr),     64'h0);
        check("frm_valid", 64'(rx_valid), 64'h1);
        check("frm_busy_cycles", 64'(busy_cycles), 64'd39);
        do_ack();
        check("frm_ack_ferr", 64'(ferr), 64'h0);

        // Back-to-back with no ack: overrun
        send_frame(32'h11111111, 1'b0, 1'b1, -1, 1'b0);
        check("b2b_first_ovr", 64'(ovr), 64'h0);
        send_frame(32'h22222222, 1'b0, 1'b1, -1, 1'b0);
        check("ovr_data",  64'(rx_data),  64'h22222222);
        check("ovr_flag",  64'(ovr),      64'h1);
        check("ovr_valid", 64'(rx_valid), 64'h1);
        do_ack();
        check("ovr_ack_clear", 64'({rx_valid, ovr}), 64'h0);

        // Back-to-back with ack in the second completion cycle: completion wins
        send_frame(32'h11111111, 1'b0, 1'b1, -1, 1'b0);
        send_frame(32'h22222222, 1'b0, 1'b1, -1, 1'b1);
        check("tie_data",  64'(rx_data),  64'h22222222);
        check("tie_ovr",   64'(ovr),      64'h0);
        check("tie_valid", 64'(rx_valid), 64'h1);
        do_ack();
        check("tie_ack_valid", 64'(rx_valid), 64'h0);

        // Reset after 10 data bits abandons the frame
        send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        check("mid_busy", 64'(rx_busy), 64'h1);
        rst = 1'b1;
        ack = 1'b1;
        tick();
        rst = 1'b0;
        ack = 1'b0;
        check("mid_rst_busy",  64'(rx_busy),  64'h0);
        check("mid_rst_valid", 64'(rx_valid), 64'h0);
        check("mid_rst_data",  64'(rx_data),  64'h0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("mid_no_delivery", 64'(rx_valid), 64'h0);
        send_frame(32'hDEADBEEF, 1'b0, 1'b1, -1, 1'b0);
        check("post_rst_data",  64'(rx_data),  64'hDEADBEEF);
        check("post_rst_valid", 64'(rx_valid), 64'h1);
        check("post_rst_flags", 64'({perr, ferr, ovr}), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
